// File: rtl/fp_div_arbiter.sv
// Round-robin arbiter sharing one pipelined FP divider among N requesters.
// An in-order tag FIFO routes each divider result back to the requester that issued it.
module fp_div_arbiter #(
    parameter int N        = 4,
    parameter int SF_WIDTH = 32,
    parameter int DEPTH    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N-1:0]              req_valid,
    input  logic [N*SF_WIDTH-1:0]     req_a,
    input  logic [N*SF_WIDTH-1:0]     req_b,
    output logic [N-1:0]              req_ack,
    output logic [SF_WIDTH-1:0]       core_a,
    output logic [SF_WIDTH-1:0]       core_b,
    output logic                      core_nd,
    input  logic                      core_rfd,
    input  logic [SF_WIDTH-1:0]       core_result,
    input  logic [3:0]                core_flags,
    input  logic                      core_rdy,
    output logic [N-1:0]              resp_valid,
    output logic [SF_WIDTH-1:0]       resp_data,
    output logic [3:0]                resp_flags,
    output logic [$clog2(DEPTH):0]    outstanding,
    output logic                      err_orphan
);

    localparam int          TW   = (N > 1) ? $clog2(N) : 1;
    localparam int          AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int          CW   = $clog2(DEPTH) + 1;
    localparam int unsigned NU   = N;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [TW-1:0] ptr;
    logic [TW-1:0] winner;
    logic [TW-1:0] cand;
    logic          found;
    logic          grant;
    logic          pop;
    logic          fifo_empty;
    int unsigned   idx;

    logic [TW-1:0] tag_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Priority search starting one past the last winner, wrapping modulo N.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        cand   = '0;
        for (int unsigned i = 1; i <= NU; i++) begin
            idx  = (32'(ptr) + i) % NU;
            cand = TW'(idx);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign fifo_empty = (outstanding == '0);
    assign pop        = core_rdy & ~fifo_empty;
    // rst is folded in so no acknowledge can escape while the block is held in reset.
    assign grant      = rst & found & core_rfd & ~core_nd & (outstanding != FULL);
    assign req_ack    = grant ? (N'(1) << winner) : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr         <= TW'(N - 1);
            core_a      <= '0;
            core_b      <= '0;
            core_nd     <= 1'b0;
            resp_valid  <= '0;
            resp_data   <= '0;
            resp_flags  <= '0;
            outstanding <= '0;
            err_orphan  <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                tag_mem[i] <= '0;
            end
        end else begin
            core_nd    <= grant;
            resp_valid <= '0;

            if (grant) begin
                ptr             <= winner;
                core_a          <= req_a[winner*SF_WIDTH +: SF_WIDTH];
                core_b          <= req_b[winner*SF_WIDTH +: SF_WIDTH];
                tag_mem[wr_ptr] <= winner;
                wr_ptr          <= wr_ptr + 1'b1;
            end

            if (pop) begin
                resp_valid <= N'(1) << tag_mem[rd_ptr];
                resp_data  <= core_result;
                resp_flags <= core_flags;
                rd_ptr     <= rd_ptr + 1'b1;
            end

            if (core_rdy && fifo_empty) begin
                err_orphan <= 1'b1;
            end

            case ({grant, pop})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

endmodule
